// File: rtl/sensor_trace_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : sensor_trace_pkg                                            |
// | Brief   : Shared types and default sizes for the sensor trace capture |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package sensor_trace_pkg;

    localparam int c_def_sample_w = 8;
    localparam int c_def_nch      = 2;
    localparam int c_def_depth    = 2048;
    localparam int c_decim_w      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_READ  = 2'd3
    } trace_state_t;

endpackage
`default_nettype wire

// File: rtl/sensor_trace_capture_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : trace_ram                                                   |
// | Brief   : Simple dual-port RAM, one write port, registered read port  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module trace_ram
    import sensor_trace_pkg::*;
#(
    parameter int WIDTH = c_def_sample_w,
    parameter int DEPTH = c_def_depth,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sensor_trace_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : sensor_trace_capture                                        |
// | Brief   : Multi-channel circular trace recorder with byte readout     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sensor_trace_capture
    import sensor_trace_pkg::*;
#(
    parameter int SAMPLE_W = c_def_sample_w,
    parameter int NCH      = c_def_nch,
    parameter int DEPTH    = c_def_depth,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm_i,
    input  logic                    trig_i,
    input  logic [AW-1:0]           pre_len_i,
    input  logic [c_decim_w-1:0]    decim_i,
    input  logic [NCH-1:0]          ch_mask_i,
    input  logic [NCH*SAMPLE_W-1:0] sample_i,
    input  logic                    sample_vld_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_vld_o,
    input  logic                    tx_rdy_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    trig_early_o
);

    localparam int            c_ch_w     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW:0]   c_depth    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_one_aw1  = (AW+1)'(1);
    localparam logic [AW-1:0] c_one_aw   = AW'(1);

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [c_ch_w:0] find_ch(input logic [NCH-1:0] mask, input int from);
        logic [c_ch_w:0] res;
        res = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (mask[c] && c >= from) res = {1'b1, c_ch_w'(c)};
        end
        return res;
    endfunction

    trace_state_t         r_state;
    logic [AW-1:0]        r_pre_len;
    logic [c_decim_w-1:0] r_decim;
    logic [c_decim_w-1:0] r_dec_cnt;
    logic [NCH-1:0]       r_ch_mask;
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_start_addr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW-1:0]        r_rd_cnt;
    logic [AW:0]          r_fill_cnt;
    logic [AW:0]          r_post_left;
    logic [c_ch_w-1:0]    r_rd_ch;
    logic [c_ch_w-1:0]    r_ram_ch;
    logic                 r_issue_done;
    logic                 r_ram_vld;
    logic [1:0]           r_cnt;
    logic [7:0]           r_out_data;
    logic [7:0]           r_skid_data;
    logic                 r_done;
    logic                 r_trig_early;

    logic                 w_in_capture;
    logic                 w_kept;
    logic                 w_we;
    logic                 w_trig_ok;
    logic                 w_post_end;
    logic                 w_pop;
    logic [1:0]           w_occ;
    logic                 w_issue;
    logic                 w_final;
    logic [c_ch_w:0]      w_first;
    logic [c_ch_w:0]      w_next;
    logic [7:0]           w_ram_byte;
    logic [SAMPLE_W-1:0]  w_rd_data [NCH];

    assign w_in_capture = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_kept       = sample_vld_i && (r_dec_cnt == '0) && w_in_capture;
    // Once the post window is complete the oldest pre-trigger sample must survive.
    assign w_we         = w_kept && ((r_state == ST_ARMED) || (r_post_left != '0));
    assign w_trig_ok    = (r_state == ST_ARMED) && trig_i && (r_fill_cnt >= {1'b0, r_pre_len});
    assign w_post_end   = (r_state == ST_POST) &&
                          ((r_post_left == '0) || (w_kept && (r_post_left == c_one_aw1)));

    assign w_pop   = tx_vld_o && tx_rdy_i;
    assign w_occ   = r_cnt + {1'b0, r_ram_vld};
    // Reads in flight plus buffered bytes never exceed the two-entry output buffer.
    assign w_issue = (r_state == ST_READ) && !r_issue_done &&
                     ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));
    assign w_final = (r_state == ST_READ) && r_issue_done && !r_ram_vld &&
                     ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop));

    assign w_first = find_ch(r_ch_mask, 0);
    assign w_next  = find_ch(r_ch_mask, int'(r_rd_ch) + 1);

    always_comb begin
        w_ram_byte                 = '0;
        w_ram_byte[SAMPLE_W-1:0]   = w_rd_data[r_ram_ch];
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        trace_ram #(
            .WIDTH (SAMPLE_W),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_we),
            .i_waddr (r_wr_ptr),
            .i_wdata (sample_i[g*SAMPLE_W +: SAMPLE_W]),
            .i_re    (w_issue),
            .i_raddr (r_rd_ptr),
            .o_rdata (w_rd_data[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pre_len    <= '0;
            r_decim      <= '0;
            r_dec_cnt    <= '0;
            r_ch_mask    <= '0;
            r_wr_ptr     <= '0;
            r_start_addr <= '0;
            r_rd_ptr     <= '0;
            r_rd_cnt     <= '0;
            r_fill_cnt   <= '0;
            r_post_left  <= '0;
            r_rd_ch      <= '0;
            r_issue_done <= 1'b0;
            r_done       <= 1'b0;
            r_trig_early <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_in_capture && sample_vld_i)
                r_dec_cnt <= (r_dec_cnt == r_decim) ? '0 : r_dec_cnt + 4'd1;
            if (w_we)
                r_wr_ptr <= r_wr_ptr + c_one_aw;

            case (r_state)
                ST_IDLE: begin
                    if (arm_i) begin
                        r_pre_len    <= pre_len_i;
                        r_decim      <= decim_i;
                        r_ch_mask    <= ch_mask_i;
                        r_wr_ptr     <= '0;
                        r_fill_cnt   <= '0;
                        r_dec_cnt    <= '0;
                        r_trig_early <= 1'b0;
                        r_state      <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_kept && (r_fill_cnt != c_depth))
                        r_fill_cnt <= r_fill_cnt + c_one_aw1;
                    if (w_trig_ok) begin
                        r_start_addr <= r_wr_ptr - r_pre_len;
                        r_post_left  <= c_depth - {1'b0, r_pre_len} - {{AW{1'b0}}, w_kept};
                        r_state      <= ST_POST;
                    end else if (trig_i) begin
                        r_trig_early <= 1'b1;
                    end
                end
                ST_POST: begin
                    if (w_kept && (r_post_left != '0))
                        r_post_left <= r_post_left - c_one_aw1;
                    if (w_post_end) begin
                        r_rd_ptr     <= r_start_addr;
                        r_rd_cnt     <= '0;
                        r_rd_ch      <= w_first[c_ch_w-1:0];
                        r_issue_done <= ~w_first[c_ch_w];
                        r_state      <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        r_rd_ptr <= r_rd_ptr + c_one_aw;
                        r_rd_cnt <= r_rd_cnt + c_one_aw;
                        if (r_rd_cnt == '1) begin
                            if (w_next[c_ch_w]) r_rd_ch <= w_next[c_ch_w-1:0];
                            else                r_issue_done <= 1'b1;
                        end
                    end
                    if (w_final) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Two-entry output buffer: r_out_data is the presented byte, r_skid_data the spare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_vld   <= 1'b0;
            r_ram_ch    <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_skid_data <= '0;
        end else begin
            r_ram_vld <= w_issue;
            r_ram_ch  <= r_rd_ch;
            case ({r_ram_vld, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_out_data  <= w_ram_byte;
                    else               r_skid_data <= w_ram_byte;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_out_data <= r_skid_data;
                    r_cnt      <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_out_data <= w_ram_byte;
                    end else begin
                        r_out_data  <= r_skid_data;
                        r_skid_data <= w_ram_byte;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data_o    = r_out_data;
    assign tx_vld_o     = (r_cnt != 2'd0);
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = r_done;
    assign trig_early_o = r_trig_early;

endmodule
`default_nettype wire

// File: tb/tb_sensor_trace_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_sensor_trace_capture                                     |
// | Brief   : Scoreboard bench for sensor_trace_capture (DEPTH=16, NCH=2) |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_sensor_trace_capture;

    localparam int SAMPLE_W = 8;
    localparam int NCH      = 2;
    localparam int DEPTH    = 16;
    localparam int AW       = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    arm_i;
    logic                    trig_i;
    logic [AW-1:0]           pre_len_i;
    logic [3:0]              decim_i;
    logic [NCH-1:0]          ch_mask_i;
    logic [NCH*SAMPLE_W-1:0] sample_i;
    logic                    sample_vld_i;
    logic [7:0]              tx_data_o;
    logic                    tx_vld_o;
    logic                    tx_rdy_i;
    logic                    busy_o;
    logic                    done_o;
    logic                    trig_early_o;

    sensor_trace_capture #(
        .SAMPLE_W (SAMPLE_W),
        .NCH      (NCH),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arm_i        (arm_i),
        .trig_i       (trig_i),
        .pre_len_i    (pre_len_i),
        .decim_i      (decim_i),
        .ch_mask_i    (ch_mask_i),
        .sample_i     (sample_i),
        .sample_vld_i (sample_vld_i),
        .tx_data_o    (tx_data_o),
        .tx_vld_o     (tx_vld_o),
        .tx_rdy_i     (tx_rdy_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .trig_early_o (trig_early_o)
    );

    always #5 clk = ~clk;

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sample(input int n);
        logic [7:0] b;
        b        = n[7:0];
        sample_i = {~b, b};
    endtask

    // Monitor: every handshake pops the scoreboard; stalls must hold data.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                n_tests++;
                if (!tx_vld_o || tx_data_o !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: vld=%0b data=%0h required vld=1 data=%0h",
                             tx_vld_o, tx_data_o, prev_data);
                end
            end
            if (tx_vld_o && tx_rdy_i) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h with no byte expected", tx_data_o);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data_o !== e) begin
                        n_fail++;
                        $display("FAIL byte: got %0h expected %0h", tx_data_o, e);
                    end
                end
            end
            if (done_o) done_cnt++;
            prev_stall <= tx_vld_o && !tx_rdy_i;
            prev_data  <= tx_data_o;
        end
    end

    // Reference: the kept stream is every (d+1)-th sample after arm; the trace is
    // the DEPTH kept samples starting pre_len before the trigger position.
    task automatic push_expected(input int trig_k, input int pre, input int d, input int mask);
        for (int ch = 0; ch < NCH; ch++) begin
            if (mask[ch]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    int         sn;
                    logic [7:0] v;
                    sn = (trig_k - pre + i) * (d + 1);
                    v  = sn[7:0];
                    exp_q.push_back((ch == 1) ? ~v : v);
                end
            end
        end
    endtask

    task automatic run_capture(input int pre, input int d, input int mask, input int early_at,
                               input int trig_at, input bit rdy_rand, input int abort_after);
        int n, kc, n_last, cyc_last, done0, total;
        bit accepted, early_seen;
        done0    = done_cnt;
        total    = (mask[0] + mask[1]) * DEPTH;
        arm_i     = 1'b1;
        pre_len_i = AW'(pre);
        decim_i   = 4'(d);
        ch_mask_i = NCH'(mask);
        trig_i    = 1'b0;
        tx_rdy_i  = 1'b1;
        set_sample(0);
        step();
        arm_i = 1'b0;
        check("busy_after_arm", busy_o, 1);
        check("early_clear_on_arm", trig_early_o, 0);
        n = 0; kc = 0; n_last = -1; cyc_last = -10; accepted = 0;
        for (int c = 0; c < 3000 && done_cnt == done0; c++) begin
            set_sample(n);
            tx_rdy_i   = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            trig_i     = !accepted && (n == early_at || n == trig_at);
            early_seen = 0;
            if (trig_i) begin
                if (kc >= pre) begin
                    accepted = 1;
                    push_expected(kc, pre, d, mask);
                    n_last = (kc - pre + DEPTH - 1) * (d + 1);
                end else begin
                    early_seen = 1;
                end
            end
            if (accepted && n == n_last) cyc_last = c;
            if (n % (d + 1) == 0) kc++;
            step();
            trig_i = 1'b0;
            if (early_seen) begin
                check("trig_early_set", trig_early_o, 1);
                check("armed_after_early", busy_o, 1);
            end
            if (c == cyc_last + 1) begin
                check("done_at_read_plus1", done_o, (mask == 0) ? 1 : 0);
                check("no_vld_at_read_plus1", tx_vld_o, 0);
            end
            if (c == cyc_last + 2 && mask != 0) check("first_vld_latency", tx_vld_o, 1);
            if (abort_after > 0 && accepted && exp_q.size() <= total - abort_after) begin
                rst = 1'b1;
                #1;
                check("rst_async_vld", tx_vld_o, 0);
                check("rst_async_busy", busy_o, 0);
                step();
                check("rst_data", tx_data_o, 0);
                check("rst_done", done_o, 0);
                check("rst_early", trig_early_o, 0);
                rst = 1'b0;
                exp_q.delete();
                step();
                return;
            end
            n++;
        end
        if (done_cnt == done0) begin
            n_fail++;
            $display("FAIL done_timeout: no done pulse, %0d bytes still expected", exp_q.size());
        end
        check("done_single_pulse", done_cnt - done0, 1);
        check("done_low_after", done_o, 0);
        check("busy_low_after", busy_o, 0);
        check("vld_low_after", tx_vld_o, 0);
        check("bytes_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; arm_i = 1'b0; trig_i = 1'b0; pre_len_i = '0; decim_i = '0;
        ch_mask_i = '0; sample_i = '0; sample_vld_i = 1'b1; tx_rdy_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", tx_data_o, 0);
        check("reset_vld", tx_vld_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_early", trig_early_o, 0);
        rst = 1'b0;
        step();

        run_capture(4, 0, 1, -1, 10, 0, 0);   // pre/post split
        run_capture(8, 0, 1, 3, 12, 0, 0);    // early trigger then accepted
        run_capture(0, 2, 3, -1, 0, 0, 0);    // decimation and mask order
        run_capture(4, 0, 1, -1, 10, 1, 0);   // backpressure
        run_capture(4, 0, 0, -1, 10, 0, 0);   // empty mask
        run_capture(4, 0, 3, -1, 10, 1, 5);   // reset mid-readout
        run_capture(4, 0, 3, -1, 10, 1, 0);   // full capture after reset

        repeat (12) begin
            int pre, d, mask, early_at, trig_at;
            pre      = $urandom_range(0, DEPTH - 2);
            d        = $urandom_range(0, 3);
            mask     = $urandom_range(0, 3);
            early_at = (pre > 0 && $urandom_range(0, 1) == 1) ?
                       int'($urandom_range(0, (pre - 1) * (d + 1))) : -1;
            trig_at  = (pre + int'($urandom_range(0, 20))) * (d + 1) + int'($urandom_range(0, d));
            run_capture(pre, d, mask, early_at, trig_at, 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
